// File: rtl/fib_seq_gen.sv
// fib_seq_gen: handshaked Fibonacci term generator with seeding, single-step
// and prescaled free-running modes, and sticky overflow detection.
// Optional build macro FIB_SAT_EN: saturate on carry and halt on the next
// handshake instead of wrapping modulo 2^WIDTH.
module fib_seq_gen #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned IDX_W    = 8,
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] seed_data,
  input  logic             load_a,
  input  logic             load_b,
  input  logic             step,
  input  logic             run_mode,
  output logic [WIDTH-1:0] out_value,
  output logic [IDX_W-1:0] out_index,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, PRESENT, WAIT_TICK, HALT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, val_q, val_d;
  logic [IDX_W-1:0] idx_q, idx_d, oidx_q, oidx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d, valid_q, valid_d, busy_q, busy_d;
  logic [WIDTH:0]   sum_c;
  logic             load_c;

  // State and datapath registers; synchronous reset wins over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= WIDTH'(1);
      val_q   <= '0;
      idx_q   <= '0;
      oidx_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      val_q   <= val_d;
      idx_q   <= idx_d;
      oidx_q  <= oidx_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state, advance arithmetic and registered-output precompute
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    val_d   = val_q;
    idx_d   = idx_q;
    oidx_d  = oidx_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sum_c   = {1'b0, a_q} + {1'b0, b_q};
    load_c  = load_a | load_b;

    case (state_q)
      IDLE: begin
        if (load_c) begin
          if (load_a) a_d = seed_data;
          if (load_b) b_d = seed_data;
          idx_d = '0;
          ovf_d = 1'b0;
        end else if (step || run_mode) begin
          state_d = PRESENT;
          val_d   = a_q;
          oidx_d  = idx_q;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          state_d = run_mode ? WAIT_TICK : IDLE;
          cnt_d   = '0;
`ifdef FIB_SAT_EN
          if (ovf_q) begin
            state_d = HALT;
          end else begin
            a_d   = b_q;
            b_d   = sum_c[WIDTH] ? {WIDTH{1'b1}} : sum_c[WIDTH-1:0];
            idx_d = idx_q + IDX_W'(1);
            ovf_d = sum_c[WIDTH];
          end
`else
          a_d   = b_q;
          b_d   = sum_c[WIDTH-1:0];
          idx_d = idx_q + IDX_W'(1);
          ovf_d = ovf_q | sum_c[WIDTH];
`endif
        end
      end
      WAIT_TICK: begin
        if (cnt_q == CNT_W'(TICK_DIV - 2)) begin
          if (run_mode) begin
            state_d = PRESENT;
            val_d   = a_q;
            oidx_d  = idx_q;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HALT: begin
        if (load_c) begin
          if (load_a) a_d = seed_data;
          if (load_b) b_d = seed_data;
          idx_d   = '0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == PRESENT);
    busy_d  = (state_d != IDLE);
  end

  assign out_value = val_q;
  assign out_index = oidx_q;
  assign out_valid = valid_q;
  assign overflow  = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Directed bench for fib_seq_gen (WIDTH=8, TICK_DIV=4); honours FIB_SAT_EN.
module tb_fib_seq_gen;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned IDX_W    = 8;
  localparam int unsigned TICK_DIV = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] seed_data;
  logic             load_a, load_b, step, run_mode, out_ready;
  logic [WIDTH-1:0] out_value;
  logic [IDX_W-1:0] out_index;
  logic             out_valid, overflow, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fib_seq_gen #(.WIDTH(WIDTH), .IDX_W(IDX_W), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .reset(reset), .seed_data(seed_data), .load_a(load_a),
    .load_b(load_b), .step(step), .run_mode(run_mode), .out_value(out_value),
    .out_index(out_index), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    seed_data = '0; load_a = 0; load_b = 0; step = 0; run_mode = 0; out_ready = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    step = 1; run_mode = 1; load_a = 1; seed_data = 8'hAA;
    reset = 1;
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 ||
        out_value !== 8'd0 || out_index !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b busy=%b ovf=%b val=%0d idx=%0d, want 0 0 0 0 0",
               out_valid, busy, overflow, out_value, out_index);
    end
    reset = 0;
    idle_inputs();
  endtask

  task automatic test_single_step();
    logic [7:0] exp_v [6];
    exp_v = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step = 1;
      tick();
      step = 0;
      checks++;
      if (out_valid !== 1'b1 || out_value !== exp_v[k] || out_index !== 8'(k)) begin
        errors++;
        $display("FAIL single_step_term%0d: valid=%b val=%0d idx=%0d, want 1 %0d %0d",
                 k, out_valid, out_value, out_index, exp_v[k], k);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL single_step_drop%0d: valid=%b busy=%b, want 0 0", k, out_valid, busy);
      end
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL single_step_ovf: overflow=%b, want 0", overflow);
    end
  endtask

  task automatic test_backpressure();
    int rise [6];
    logic [7:0] rval [6];
    logic [7:0] exp_v [6];
    int n = 0;
    int hold = 0;
    int cyc = 0;
    logic prev_v = 1'b0;
    exp_v = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5};
    do_reset();
    run_mode = 1;
    while (n < 6 && cyc < 120) begin
      tick();
      cyc++;
      if (out_valid && !prev_v) begin
        rise[n] = cyc;
        rval[n] = out_value;
        n++;
      end
      prev_v = out_valid;
      if (out_valid && out_index == 8'd2 && hold < 10) begin
        checks++;
        if (out_value !== 8'd1 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL bp_hold%0d: valid=%b val=%0d, want 1 1", hold, out_valid, out_value);
        end
        out_ready = 0;
        hold++;
      end else begin
        out_ready = 1;
      end
    end
    run_mode = 0;
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL bp_timeout: saw %0d terms, want 6", n);
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (rval[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL bp_value%0d: val=%0d, want %0d", k, rval[k], exp_v[k]);
        end
      end
      for (int k = 1; k < 6; k++) begin
        checks++;
        if (rise[k] - rise[k-1] != ((k == 3) ? 14 : 4)) begin
          errors++;
          $display("FAIL bp_spacing%0d: gap=%0d, want %0d", k, rise[k] - rise[k-1],
                   (k == 3) ? 14 : 4);
        end
      end
    end
    do_reset();
  endtask

  task automatic test_seed_load();
    logic [7:0] exp_v [3];
    exp_v = '{8'd5, 8'd8, 8'd13};
    do_reset();
    seed_data = 8'd5; load_a = 1; tick(); load_a = 0;
    seed_data = 8'd8; load_b = 1; tick(); load_b = 0;
    for (int k = 0; k < 3; k++) begin
      step = 1;
      tick();
      step = 0;
      checks++;
      if (out_valid !== 1'b1 || out_value !== exp_v[k] || out_index !== 8'(k)) begin
        errors++;
        $display("FAIL seed_term%0d: valid=%b val=%0d idx=%0d, want 1 %0d %0d",
                 k, out_valid, out_value, out_index, exp_v[k], k);
      end
      tick();
    end
    seed_data = 8'd3; load_a = 1; step = 1;
    tick();
    load_a = 0; step = 0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL load_beats_step: valid=%b busy=%b, want 0 0", out_valid, busy);
    end
    step = 1; tick(); step = 0;
    checks++;
    if (out_value !== 8'd3 || out_index !== 8'd0) begin
      errors++;
      $display("FAIL load_step_after: val=%0d idx=%0d, want 3 0", out_value, out_index);
    end
    tick();
  endtask

  task automatic test_overflow();
    logic [7:0] exp_v [3];
    exp_v = '{8'd89, 8'd144, 8'd233};
    do_reset();
    seed_data = 8'd89;  load_a = 1; tick(); load_a = 0;
    seed_data = 8'd144; load_b = 1; tick(); load_b = 0;
    for (int k = 0; k < 3; k++) begin
      step = 1;
      tick();
      step = 0;
      checks++;
      if (out_valid !== 1'b1 || out_value !== exp_v[k] || out_index !== 8'(k)) begin
        errors++;
        $display("FAIL ovf_term%0d: valid=%b val=%0d idx=%0d, want 1 %0d %0d",
                 k, out_valid, out_value, out_index, exp_v[k], k);
      end
      tick();
      checks++;
      if (overflow !== (k >= 1)) begin
        errors++;
        $display("FAIL ovf_flag%0d: overflow=%b, want %0d", k, overflow, (k >= 1));
      end
    end
`ifdef FIB_SAT_EN
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_entry: busy=%b valid=%b, want 1 0", busy, out_valid);
    end
    step = 1; tick(); tick(); step = 0;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_step_ignored: busy=%b valid=%b, want 1 0", busy, out_valid);
    end
`else
    step = 1; tick(); step = 0;
    checks++;
    if (out_valid !== 1'b1 || out_value !== 8'd121 || out_index !== 8'd3) begin
      errors++;
      $display("FAIL wrap_term3: valid=%b val=%0d idx=%0d, want 1 121 3",
               out_valid, out_value, out_index);
    end
    tick();
`endif
    seed_data = 8'd1; load_a = 1; tick(); load_a = 0;
    checks++;
    if (overflow !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL load_clears_ovf: overflow=%b busy=%b, want 0 0", overflow, busy);
    end
    step = 1; tick(); step = 0;
    checks++;
    if (out_value !== 8'd1 || out_index !== 8'd0) begin
      errors++;
      $display("FAIL after_load_term: val=%0d idx=%0d, want 1 0", out_value, out_index);
    end
    tick();
  endtask

  task automatic test_reset_mid_present();
    do_reset();
    seed_data = 8'd9; load_a = 1; load_b = 1; tick(); load_a = 0; load_b = 0;
    out_ready = 0;
    step = 1; tick(); step = 0;
    checks++;
    if (out_valid !== 1'b1 || out_value !== 8'd9) begin
      errors++;
      $display("FAIL mid_present: valid=%b val=%0d, want 1 9", out_valid, out_value);
    end
    reset = 1; tick(); reset = 0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_value !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b busy=%b val=%0d, want 0 0 0", out_valid, busy, out_value);
    end
    out_ready = 1;
    for (int k = 0; k < 2; k++) begin
      step = 1; tick(); step = 0;
      checks++;
      if (out_value !== 8'(k) || out_index !== 8'(k)) begin
        errors++;
        $display("FAIL post_reset_term%0d: val=%0d idx=%0d, want %0d %0d",
                 k, out_value, out_index, k, k);
      end
      tick();
    end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_single_step();
    test_backpressure();
    test_seed_load();
    test_overflow();
    test_reset_mid_present();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
